// File: rtl/alu_arbiter.sv
// Round-robin arbiter that shares one fixed-latency ALU between two requesters.
// Each operation is accepted, issued, waited out, and returned over a valid/ready response.
module alu_arbiter #(
  parameter int WIDTH       = 16,
  parameter int OP_W        = 3,
  parameter int ALU_LATENCY = 1
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [OP_W-1:0]  req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [OP_W-1:0]  req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic [WIDTH-1:0] rsp0_data,
  output logic             rsp0_zero,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp1_data,
  output logic             rsp1_zero,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [OP_W-1:0]  alu_op,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero,
  output logic             busy,
  output logic             grant_id
);

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, RESP = 2'd3} state_t;

  localparam logic [2:0] LAT = 3'(ALU_LATENCY);

  state_t           state_q, state_d;
  logic             ptr_q, ptr_d;
  logic             gnt_q, gnt_d;
  logic [OP_W-1:0]  op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             zero_q, zero_d;
  logic [2:0]       cnt_q, cnt_d;
  logic             any_req;
  logic             sel;

  assign any_req = req0_valid | req1_valid;
  // The pointer's requester wins if it is asking; otherwise the other one does.
  assign sel = (ptr_q ? req1_valid : req0_valid) ? ptr_q : ~ptr_q;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= IDLE;
      ptr_q   <= 1'b0;
      gnt_q   <= 1'b0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      zero_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      zero_q  <= zero_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    zero_d  = zero_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          gnt_d   = sel;
          ptr_d   = ~sel;
          op_d    = sel ? req1_op : req0_op;
          a_d     = sel ? req1_a  : req0_a;
          b_d     = sel ? req1_b  : req0_b;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = LAT;
        state_d = WAIT;
      end
      WAIT: begin
        // Count of 1 marks the cycle in which the ALU output becomes valid.
        if (cnt_q == 3'd1) begin
          res_d   = alu_result;
          zero_d  = alu_zero;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      RESP: begin
        if (gnt_q ? rsp1_ready : rsp0_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    rsp0_valid = 1'b0;
    rsp1_valid = 1'b0;
    busy       = (state_q != IDLE);
    case (state_q)
      // Ready is gated by reset so every output reads 0 while reset is held.
      IDLE: begin
        if (any_req && RESET_N) begin
          req0_ready = ~sel;
          req1_ready = sel;
        end
      end
      RESP: begin
        rsp0_valid = ~gnt_q;
        rsp1_valid = gnt_q;
      end
      default: ;
    endcase
  end

  assign alu_a     = a_q;
  assign alu_b     = b_q;
  assign alu_op    = op_q;
  assign grant_id  = gnt_q;
  assign rsp0_data = res_q;
  assign rsp1_data = res_q;
  assign rsp0_zero = zero_q;
  assign rsp1_zero = zero_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: latency-1 instance with ALU model plus a latency-3 instance.
module tb_alu_arbiter;
  localparam int W = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic [1:0]   rv, rr;
  logic [2:0]   rop [2];
  logic [W-1:0] ra [2];
  logic [W-1:0] rb [2];
  logic req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_zero, rsp1_zero;
  logic busy, grant_id, alu_zero;
  logic [W-1:0] rsp0_data, rsp1_data, alu_a, alu_b, alu_result, alu_q;
  logic [2:0] alu_op;

  logic [1:0]   rdy, rspv, rspz;
  logic [W-1:0] rspd [2];
  assign rdy  = {req1_ready, req0_ready};
  assign rspv = {rsp1_valid, rsp0_valid};
  assign rspz = {rsp1_zero, rsp0_zero};
  assign rspd[0] = rsp0_data;
  assign rspd[1] = rsp1_data;

  // Latency-3 instance signals
  logic t_v, t_rr, t_r0rdy, t_r1rdy, t_rsp0v, t_rsp1v, t_rsp0z, t_rsp1z, t_busy, t_gid, t_alu_zero;
  logic [2:0] t_op, t_alu_op;
  logic [W-1:0] t_a, t_b, t_rsp0d, t_rsp1d, t_alu_a, t_alu_b, t_alu_result;
  logic [W-1:0] p3 [3];

  function automatic logic [W-1:0] alu_f(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return a ^ b;
      3'd5: return (a < b) ? 16'd1 : 16'd0;
      3'd6: return a << 1;
      default: return a >> 1;
    endcase
  endfunction

  always @(posedge clk) begin
    alu_q <= alu_f(alu_op, alu_a, alu_b);
    p3[0] <= alu_f(t_alu_op, t_alu_a, t_alu_b);
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end
  assign alu_result   = alu_q;
  assign alu_zero     = (alu_q == '0);
  assign t_alu_result = p3[2];
  assign t_alu_zero   = (p3[2] == '0);

  alu_arbiter #(.WIDTH(W), .OP_W(3), .ALU_LATENCY(1)) dut (
    .CLK(clk), .RESET_N(rst_n),
    .req0_valid(rv[0]), .req0_ready(req0_ready), .req0_op(rop[0]), .req0_a(ra[0]), .req0_b(rb[0]),
    .req1_valid(rv[1]), .req1_ready(req1_ready), .req1_op(rop[1]), .req1_a(ra[1]), .req1_b(rb[1]),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rr[0]), .rsp0_data(rsp0_data), .rsp0_zero(rsp0_zero),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rr[1]), .rsp1_data(rsp1_data), .rsp1_zero(rsp1_zero),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result), .alu_zero(alu_zero),
    .busy(busy), .grant_id(grant_id)
  );

  alu_arbiter #(.WIDTH(W), .OP_W(3), .ALU_LATENCY(3)) dut3 (
    .CLK(clk), .RESET_N(rst_n),
    .req0_valid(t_v), .req0_ready(t_r0rdy), .req0_op(t_op), .req0_a(t_a), .req0_b(t_b),
    .req1_valid(1'b0), .req1_ready(t_r1rdy), .req1_op(3'd0), .req1_a(16'd0), .req1_b(16'd0),
    .rsp0_valid(t_rsp0v), .rsp0_ready(t_rr), .rsp0_data(t_rsp0d), .rsp0_zero(t_rsp0z),
    .rsp1_valid(t_rsp1v), .rsp1_ready(1'b1), .rsp1_data(t_rsp1d), .rsp1_zero(t_rsp1z),
    .alu_a(t_alu_a), .alu_b(t_alu_b), .alu_op(t_alu_op), .alu_result(t_alu_result), .alu_zero(t_alu_zero),
    .busy(t_busy), .grant_id(t_gid)
  );

  typedef struct packed {logic id; logic [W-1:0] d; logic z;} exp_t;
  exp_t q[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: bound expired at %0t", name, $time);
  endtask

  // Scoreboard monitor
  logic [1:0]   pv, pr, pz;
  logic [W-1:0] pd [2];
  always @(negedge clk) begin
    if (rst_n) begin
      chk("one_ready", 32'(rdy == 2'b11), 32'd0);
      for (int n = 0; n < 2; n++) begin
        if (pv[n] && !pr[n]) begin
          chk("hold_valid", 32'(rspv[n]), 32'd1);
          chk("hold_data", 32'(rspd[n]), 32'(pd[n]));
          chk("hold_zero", 32'(rspz[n]), 32'(pz[n]));
        end
        if (rspv[n]) chk("rsp_owner", 32'(grant_id), 32'(n));
        if (rspv[n] && rr[n]) begin
          if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_rsp: channel %0d data 0x%0h, no response expected", n, rspd[n]);
          end else begin
            chk("rsp_id", 32'(n), 32'(q[0].id));
            chk("rsp_data", 32'(rspd[n]), 32'(q[0].d));
            chk("rsp_zero", 32'(rspz[n]), 32'(q[0].z));
            void'(q.pop_front());
          end
        end
        pv[n] <= rspv[n];
        pr[n] <= rr[n];
        pd[n] <= rspd[n];
        pz[n] <= rspz[n];
      end
    end else begin
      pv <= 2'b00;
      pr <= 2'b00;
    end
  end

  task automatic wait_ready(input int id);
    int n;
    n = 0;
    #1;
    while (!rdy[id] && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!rdy[id]) fail_now("req_ready_timeout");
  endtask

  task automatic drive(input int id, input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    rop[id] = op;
    ra[id]  = a;
    rb[id]  = b;
    rv[id]  = 1'b1;
    wait_ready(id);
    @(posedge clk);
    #1 rv[id] = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q.size() != 0 || busy) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0 || busy) fail_now("drain_timeout");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    rst_n = 1'b0;
    rv = 2'b00;
    rr = 2'b11;
    for (int i = 0; i < 2; i++) begin
      rop[i] = '0;
      ra[i] = '0;
      rb[i] = '0;
    end
    t_v = 1'b0; t_rr = 1'b1; t_op = '0; t_a = '0; t_b = '0;
    #12;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_grant", 32'(grant_id), 0);
    chk("rst_alu_a", 32'(alu_a), 0);
    chk("rst_alu_op", 32'(alu_op), 0);
    chk("rst_rsp_valid", 32'(rspv), 0);
    chk("rst_rsp_data", 32'(rsp0_data), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single op: 3 + 5
    q.push_back(exp_t'{1'b0, 16'h0008, 1'b0});
    rop[0] = 3'd0; ra[0] = 16'h0003; rb[0] = 16'h0005; rv[0] = 1'b1;
    wait_ready(0);
    chk("k_req0_ready", 32'(req0_ready), 1);
    chk("k_req1_ready", 32'(req1_ready), 0);
    @(posedge clk);
    #1 rv[0] = 1'b0;
    @(negedge clk);
    chk("k1_alu_op", 32'(alu_op), 0);
    chk("k1_alu_a", 32'(alu_a), 32'h3);
    chk("k1_alu_b", 32'(alu_b), 32'h5);
    chk("k1_busy", 32'(busy), 1);
    @(negedge clk);
    chk("k2_rsp0_valid", 32'(rsp0_valid), 0);
    @(negedge clk);
    chk("k3_rsp0_valid", 32'(rsp0_valid), 1);
    @(negedge clk);
    chk("k4_busy", 32'(busy), 0);

    // Zero path
    q.push_back(exp_t'{1'b0, 16'h0000, 1'b1});
    q.push_back(exp_t'{1'b0, 16'h0000, 1'b1});
    drive(0, 3'd1, 16'h1234, 16'h1234);
    drive(0, 3'd0, 16'hFFFF, 16'h0001);
    drain();

    // Reset during WAIT drops the op; pointer returns to 0
    @(negedge clk);
    drive(0, 3'd2, 16'h5555, 16'h00FF);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_alu_a", 32'(alu_a), 0);
    chk("mid_rst_alu_op", 32'(alu_op), 0);
    chk("mid_rst_rsp0_valid", 32'(rsp0_valid), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("post_rst_idle", 32'(busy), 0);
    end

    // Contention: strict alternation starting with requester 0
    q.push_back(exp_t'{1'b0, 16'h0003, 1'b0});
    q.push_back(exp_t'{1'b1, 16'h000F, 1'b0});
    q.push_back(exp_t'{1'b0, 16'h0001, 1'b0});
    q.push_back(exp_t'{1'b1, 16'hF00F, 1'b0});
    q.push_back(exp_t'{1'b0, 16'h0001, 1'b0});
    q.push_back(exp_t'{1'b1, 16'h0000, 1'b1});
    q.push_back(exp_t'{1'b0, 16'h0000, 1'b1});
    q.push_back(exp_t'{1'b1, 16'h8002, 1'b0});
    fork
      begin
        drive(0, 3'd0, 16'h0001, 16'h0002);
        drive(0, 3'd7, 16'h0002, 16'h0000);
        drive(0, 3'd5, 16'h0003, 16'h0004);
        drive(0, 3'd1, 16'h0005, 16'h0005);
      end
      begin
        drive(1, 3'd2, 16'h00FF, 16'h0F0F);
        drive(1, 3'd3, 16'hF000, 16'h000F);
        drive(1, 3'd4, 16'hAAAA, 16'hAAAA);
        drive(1, 3'd6, 16'h4001, 16'h0000);
      end
    join
    drain();

    // Backpressure on rsp1 while req0 waits
    @(posedge clk);
    #1 rr[1] = 1'b0;
    q.push_back(exp_t'{1'b1, 16'h00F0, 1'b0});
    q.push_back(exp_t'{1'b0, 16'h1234, 1'b0});
    drive(1, 3'd2, 16'hF0F0, 16'h0FF0);
    rop[0] = 3'd3; ra[0] = 16'h1200; rb[0] = 16'h0034; rv[0] = 1'b1;
    n = 0;
    while (!rsp1_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!rsp1_valid) fail_now("rsp1_valid_timeout");
    repeat (5) begin
      chk("bp_rsp1_valid", 32'(rsp1_valid), 1);
      chk("bp_rsp1_data", 32'(rsp1_data), 32'h00F0);
      chk("bp_req0_ready", 32'(req0_ready), 0);
      chk("bp_busy", 32'(busy), 1);
      @(negedge clk);
    end
    @(posedge clk);
    #1 rr[1] = 1'b1;
    @(negedge clk);
    chk("hs_req0_ready", 32'(req0_ready), 0);
    @(negedge clk);
    chk("after_hs_req0_ready", 32'(req0_ready), 1);
    @(posedge clk);
    #1 rv[0] = 1'b0;
    drain();

    // Latency-3 instance: 0x00FF ^ 0x0F0F
    @(negedge clk);
    t_op = 3'd4; t_a = 16'h00FF; t_b = 16'h0F0F; t_v = 1'b1;
    #1;
    n = 0;
    while (!t_r0rdy && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("l3_ready", 32'(t_r0rdy), 1);
    @(posedge clk);
    #1 t_v = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      chk("l3_alu_a", 32'(t_alu_a), 32'h00FF);
      chk("l3_alu_b", 32'(t_alu_b), 32'h0F0F);
      chk("l3_alu_op", 32'(t_alu_op), 32'd4);
      chk("l3_rsp_early", 32'(t_rsp0v), 0);
    end
    @(negedge clk);
    chk("l3_rsp_valid", 32'(t_rsp0v), 1);
    chk("l3_rsp_data", 32'(t_rsp0d), 32'h0FF0);
    chk("l3_rsp_zero", 32'(t_rsp0z), 0);
    chk("l3_alu_a_k5", 32'(t_alu_a), 32'h00FF);
    chk("l3_rsp1_valid", 32'(t_rsp1v), 0);
    @(negedge clk);
    chk("l3_busy_done", 32'(t_busy), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Sequences and shares the single 16-bit ALU between two requesters, e.g. requester 0 = instruction datapath and requester 1 = PC/address update path.
- Accepts one operation at a time over a valid/ready handshake and grants round-robin.
- Drives the ALU operand and op inputs from internal hold registers and waits the ALU's fixed latency.
- Captures the result and Zero flag, then returns them to the granted requester over a valid/ready response channel.

Parameters:
- WIDTH, 16, operand/result width; must match the ALU data width.
- OP_W, 3, ALU op code width.
- ALU_LATENCY, 1, number of CLK edges from the ALU sampling its inputs to its result being valid; legal range 1..7.

Ports:
- CLK  input  1  single clock, rising edge.
- RESET_N  input  1  asynchronous, active-low reset.
- req0_valid  input  1  requester 0 has an operation pending.
- req0_ready  output  1  requester 0 operation accepted this cycle.
- req0_op  input  OP_W  ALU op for requester 0.
- req0_a  input  WIDTH  first operand for requester 0.
- req0_b  input  WIDTH  second operand for requester 0.
- req1_valid, req1_ready, req1_op, req1_a, req1_b: same as requester 0, for requester 1.
- rsp0_valid  output  1  result for requester 0 available.
- rsp0_ready  input  1  requester 0 takes the result.
- rsp0_data  output  WIDTH  result.
- rsp0_zero  output  1  ALU Zero flag captured with the result.
- rsp1_valid, rsp1_ready, rsp1_data, rsp1_zero: same as requester 0, for requester 1.
- alu_a  output  WIDTH  ALU first input.
- alu_b  output  WIDTH  ALU second input.
- alu_op  output  OP_W  ALU op select.
- alu_result  input  WIDTH  ALU output.
- alu_zero  input  1  ALU Zero output.
- busy  output  1  high in every state except IDLE.
- grant_id  output  1  requester currently owning the ALU.

Behaviour:
- Reset (RESET_N low, asynchronous):
  - State goes to IDLE; priority pointer = 0.
  - All outputs are 0, including alu_a, alu_b, alu_op, all ready/valid outputs, rsp data/zero, busy and grant_id.
  - Any in-flight operation is dropped and produces no response.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any reqN_valid is high, grant one requester: the pointer's requester if it is valid, otherwise the other.
  - Assert the granted reqN_ready combinationally in this cycle (cycle k) only; the other ready stays 0.
  - At the end of cycle k, latch op/a/b into the hold registers and set grant_id.
  - Set pointer = 1 - granted id.
  - Go to ISSUE.
- ISSUE (cycle k+1):
  - alu_a/alu_b/alu_op are driven from the hold registers; they stay stable until the next grant.
  - Load the latency counter with ALU_LATENCY.
  - Go to WAIT.
- WAIT:
  - Decrement the counter each cycle.
  - When the counter reaches 1, capture alu_result and alu_zero at the end of that cycle and go to RESP.
  - Capture therefore occurs at the end of cycle k+1+ALU_LATENCY.
- RESP:
  - rspN_valid (N = grant_id) is high from cycle k+2+ALU_LATENCY.
  - rspN_data/rspN_zero hold the captured values and stay stable until rspN_ready is high.
  - On the handshake cycle, go to IDLE. The new grant occurs at the earliest in the following cycle.
- Minimum occupancy is 3+ALU_LATENCY cycles per operation; no pipelining and no overlap.
- Requester rules:
  - While reqN_valid is high, reqN_op/a/b must be held stable until reqN_ready.
  - Requests arriving while busy wait; their ready stays 0.
- Simultaneous valid in IDLE: pointer decides, so the two requesters alternate strictly under continuous contention.
- rspN_ready while rspN_valid=0 is ignored.
- The non-granted rsp channel always has valid=0.
- All 8 op codes are forwarded unmodified, including op 7.
- No arithmetic is done in this block; Zero is taken from the ALU, not recomputed.
- Reset asserted mid-ISSUE/WAIT/RESP: as for reset above; after release, IDLE with pointer 0.

Test Plan:
- Reset during WAIT: assert RESET_N=0 for 1 cycle -> all outputs 0 immediately, no rsp ever issued for that op, next grant goes to requester 0.
- Single op: req0 op=0 a=0x0003 b=0x0005, ALU_LATENCY=1, rsp0_ready=1 -> req0_ready in cycle k; alu_op=0, alu_a=3, alu_b=5 from k+1; rsp0_valid at k+3 with data=0x0008, zero=0; busy low at k+4.
- Contention: req0 and req1 both valid continuously from reset, four ops each -> grant order 0,1,0,1,...; never both ready in one cycle; grant_id matches the responding channel.
- Backpressure: req1 result with rsp1_ready low for 5 cycles while req0 is valid -> rsp1_valid/data/zero held constant, req0_ready stays 0, busy=1; req0 granted the cycle after the rsp1 handshake.
- Zero path: op=1 a=b=0x1234 -> rsp data=0x0000, zero=1; then op=0 a=0xFFFF b=0x0001 -> data=0x0000 as returned by the ALU model.
- ALU_LATENCY=3 build: single op accepted at cycle k -> capture at end of k+4, rsp valid at k+5; alu inputs stable k+1..k+5.
